// File: rtl/move_controller_if.sv
// Bus between the player-input / board-register side and the turn sequencer.
// The master drives the selection, confirm pulse, board snapshot and game_over;
// the slave (move_controller) drives the write enables and turn status.
interface move_controller_if;
  logic [3:0]  sel_idx;
  logic        confirm;
  logic [17:0] board;
  logic        game_over;
  logic [8:0]  PLX_en;
  logic [8:0]  PLO_en;
  logic        illegal_move;
  logic        turn_x;
  logic [3:0]  time_left;

  modport master (
    output sel_idx, confirm, board, game_over,
    input  PLX_en, PLO_en, illegal_move, turn_x, time_left
  );

  modport slave (
    input  sel_idx, confirm, board, game_over,
    output PLX_en, PLO_en, illegal_move, turn_x, time_left
  );
endinterface

// File: rtl/move_controller.sv
// Turn sequencer feeding the board position registers. Validates the active
// player's selection against the board, issues a one-cycle one-hot write enable
// for X or O, alternates turns, and auto-plays the lowest free cell when the
// per-turn timer runs out.
module move_controller #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int TURN_SECS     = 15
) (
  input  logic             clk,
  input  logic             rst,
  move_controller_if.slave bus
);

  localparam logic [1:0] ST_WAIT   = 2'd0;
  localparam logic [1:0] ST_COMMIT = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int            PW           = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(TICKS_PER_SEC - 1);
  localparam logic [3:0]    TURN_INIT    = 4'(TURN_SECS);

  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [PW-1:0] prescaler;
  logic [3:0]    time_left_q;
  logic          turn_x_q;
  logic [8:0]    plx_en_q;
  logic [8:0]    plo_en_q;
  logic          illegal_q;

  logic [1:0]    sel_cell;
  logic          sel_legal;
  logic          free_found;
  logic [3:0]    free_idx;

  logic          go_done;
  logic          do_move;
  logic          do_illegal;
  logic          do_tick;
  logic [3:0]    move_idx;
  logic [8:0]    move_onehot;

  // Contents of the selected cell; out-of-range selections read as occupied.
  // NOTE: every signal assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel_cell = 2'b11;
    for (int k = 0; k < 9; k++) begin
      if (bus.sel_idx == 4'(k)) sel_cell = bus.board[2*k +: 2];
    end
  end

  assign sel_legal = (bus.sel_idx <= 4'd8) && (sel_cell == 2'b00);

  // Lowest-index empty cell for the timeout auto-move (scan high to low so the lowest wins).
  always_comb begin
    free_found = 1'b0;
    free_idx   = 4'd0;
    for (int k = 8; k >= 0; k--) begin
      if (bus.board[2*k +: 2] == 2'b00) begin
        free_found = 1'b1;
        free_idx   = 4'(k);
      end
    end
  end

  // Decide this cycle's action: game_over wins, then confirm, then timeout.
  always_comb begin
    go_done    = 1'b0;
    do_move    = 1'b0;
    do_illegal = 1'b0;
    do_tick    = 1'b0;
    move_idx   = free_idx;
    if (bus.game_over) begin
      go_done = 1'b1;
    end else if (state == ST_WAIT) begin
      if (bus.confirm) begin
        if (sel_legal) begin
          do_move  = 1'b1;
          move_idx = bus.sel_idx;
        end else begin
          // A rejected confirm still leaves us waiting, so the timer keeps running.
          do_illegal = 1'b1;
          do_tick    = 1'b1;
        end
      end else if (time_left_q == 4'd0) begin
        if (free_found) do_move = 1'b1;
        else            go_done = 1'b1;
      end else begin
        do_tick = 1'b1;
      end
    end
  end

  assign move_onehot = 9'(1) << move_idx;

  // Next state: WAIT -> COMMIT -> SETTLE -> WAIT, DONE absorbing.
  always_comb begin
    state_nx = state;
    if (go_done) begin
      state_nx = ST_DONE;
    end else begin
      case (state)
        ST_WAIT:   if (do_move) state_nx = ST_COMMIT;
        ST_COMMIT: state_nx = ST_SETTLE;
        ST_SETTLE: state_nx = ST_WAIT;
        default:   state_nx = ST_DONE;
      endcase
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_WAIT;
    else     state <= state_nx;
  end

  // Registered write enables and illegal strobe; each is high for at most one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plx_en_q  <= '0;
      plo_en_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      plx_en_q  <= (do_move &&  turn_x_q) ? move_onehot : 9'd0;
      plo_en_q  <= (do_move && !turn_x_q) ? move_onehot : 9'd0;
      illegal_q <= do_illegal;
    end
  end

  // Hand the turn over as the write enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 turn_x_q <= 1'b1;
    else if (!go_done && state == ST_COMMIT) turn_x_q <= ~turn_x_q;
  end

  // Turn timer: reload when a move settles, otherwise count seconds while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      time_left_q <= TURN_INIT;
    end else if (!go_done && state == ST_SETTLE) begin
      prescaler   <= '0;
      time_left_q <= TURN_INIT;
    end else if (do_tick) begin
      if (prescaler == PRESCALE_MAX) begin
        prescaler <= '0;
        if (time_left_q != 4'd0) time_left_q <= time_left_q - 4'd1;
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  assign bus.PLX_en       = plx_en_q;
  assign bus.PLO_en       = plo_en_q;
  assign bus.illegal_move = illegal_q;
  assign bus.turn_x       = turn_x_q;
  assign bus.time_left    = time_left_q;

  // Guarantees the board registers depend on.
  a_excl_enables : assert property (@(posedge clk) disable iff (rst)
    (plx_en_q & plo_en_q) == 9'd0);
  a_onehot_enables : assert property (@(posedge clk) disable iff (rst)
    $onehot0(plx_en_q) && $onehot0(plo_en_q));
  a_no_strobe_with_enable : assert property (@(posedge clk) disable iff (rst)
    !(illegal_q && ((plx_en_q | plo_en_q) != 9'd0)));

endmodule
